// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one prefix level per register stage,
// valid/ready flow control, carry-in, subtract mode, carry-out and signed overflow.
module ks_adder_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_width_check
    $error("ks_adder_pipe: WIDTH must be at least 2");
  end

  // Index 0 is the operand stage, index k holds the result of prefix level k.
  logic             advance;
  logic [WIDTH-1:0] bb;
  logic             c0;
  logic [WIDTH-1:0] g_d    [LEVELS+1];
  logic [WIDTH-1:0] g_q    [LEVELS+1];
  logic [WIDTH-1:0] p_d    [LEVELS];
  logic [WIDTH-1:0] p_q    [LEVELS];
  logic [WIDTH-1:0] rawp_d [LEVELS+1];
  logic [WIDTH-1:0] rawp_q [LEVELS+1];
  logic [LEVELS:0]  c0_d;
  logic [LEVELS:0]  c0_q;
  logic [LEVELS:0]  v_d;
  logic [LEVELS:0]  v_q;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             out_valid_d;
  logic             out_valid_q;

  // Whole pipeline moves together; a stalled output freezes every stage.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Next-state for every stage: operand conditioning, prefix levels, sum formation
  always_comb begin
    g_d         = g_q;
    p_d         = p_q;
    rawp_d      = rawp_q;
    c0_d        = c0_q;
    v_d         = v_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = v_q[LEVELS];

    // Subtraction is a + ~b + 1; the carry-in is folded into bit 0's generate
    bb        = sub ? ~b : b;
    c0        = sub ? 1'b1 : cin;
    p_d[0]    = a ^ bb;
    g_d[0]    = a & bb;
    g_d[0][0] = (a[0] & bb[0]) | ((a[0] ^ bb[0]) & c0);
    rawp_d[0] = a ^ bb;
    c0_d[0]   = c0;
    v_d[0]    = in_valid;

    // Level k combines span 2^(k-1); zeros shifted into the low columns make
    // those columns plain buffers, and columns below 2*span only need G
    for (int unsigned k = 1; k <= LEVELS; k++) begin
      g_d[k]    = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k-1))));
      rawp_d[k] = rawp_q[k-1];
      c0_d[k]   = c0_q[k-1];
      v_d[k]    = v_q[k-1];
    end

    // Group propagate is consumed only by the next level, so the last level drops it
    for (int unsigned k = 1; k < LEVELS; k++) begin
      p_d[k] = p_q[k-1] & (p_q[k-1] << (1 << (k-1)));
    end

    // Final G vector is the carry out of each column
    carry = {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
    if (v_q[LEVELS]) begin
      sum_d  = rawp_q[LEVELS] ^ carry;
      cout_d = g_q[LEVELS][WIDTH-1];
      ovf_d  = carry[WIDTH-1] ^ g_q[LEVELS][WIDTH-1];
    end
  end

  // Valid bits and result registers: cleared by reset, frozen while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  // Prefix datapath: qualified by the valid bits, so no reset is required
  always_ff @(posedge clk) begin
    if (advance) begin
      g_q    <= g_d;
      p_q    <= p_d;
      rawp_q <= rawp_d;
      c0_q   <= c0_d;
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe at WIDTH 32, 8 and 13.
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT signals, one set per width
  logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
  logic [31:0] a32, b32, s32;
  logic        iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
  logic [7:0]  a8, b8, s8;
  logic        iv13, ir13, cin13, sub13, ov13, or13, co13, of13;
  logic [12:0] a13, b13, s13;

  ks_adder_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .ovf(of32));

  ks_adder_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(of8));

  ks_adder_pipe #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13),
    .cin(cin13), .sub(sub13), .out_valid(ov13), .out_ready(or13), .sum(s13),
    .cout(co13), .ovf(of13));

  // Expected {ovf, cout, sum} entries, oldest first
  logic [33:0] q32[$];
  logic [33:0] q8[$];
  logic [33:0] q13[$];
  int unsigned n32 = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: wide add for sum/cout, operand/result signs for overflow
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin, input logic sub);
    logic [32:0] mask, bb, full;
    logic [31:0] s;
    logic        c0, co, ov;
    mask = (33'd1 << w) - 33'd1;
    bb   = sub ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
    c0   = sub ? 1'b1 : cin;
    full = ({1'b0, a} & mask) + bb + 33'(c0);
    s    = 32'(full & mask);
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // Monitors sample mid-cycle; a handshake seen here completes at the next rising edge
  logic        held32 = 1'b0, held8 = 1'b0, held13 = 1'b0;
  logic [33:0] hv32, hv8, hv13, e32, e8, e13;

  always @(negedge clk) begin
    if (rst) begin
      held32 = 1'b0;
    end else begin
      check("in_ready32", 64'(ir32), 64'(!ov32 || or32));
      if (held32) begin
        check("hold_valid32", 64'(ov32), 64'd1);
        check("hold_data32", 64'({of32, co32, s32}), 64'(hv32));
      end
      held32 = ov32 && !or32;
      hv32   = {of32, co32, s32};
      if (ov32 && or32) begin
        if (q32.size() == 0) check("spurious32", 64'(ov32), 64'd0);
        else begin
          e32 = q32.pop_front();
          n32++;
          check("sum32", 64'(s32), 64'(e32[31:0]));
          check("cout32", 64'(co32), 64'(e32[32]));
          check("ovf32", 64'(of32), 64'(e32[33]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      held8 = 1'b0;
    end else begin
      check("in_ready8", 64'(ir8), 64'(!ov8 || or8));
      if (held8) check("hold_data8", 64'({ov8, of8, co8, s8}), 64'({1'b1, hv8[33:32], hv8[7:0]}));
      held8 = ov8 && !or8;
      hv8   = {of8, co8, 24'd0, s8};
      if (iv8 && ir8) q8.push_back(model(8, 32'(a8), 32'(b8), cin8, sub8));
      if (ov8 && or8) begin
        if (q8.size() == 0) check("spurious8", 64'(ov8), 64'd0);
        else begin
          e8 = q8.pop_front();
          check("sum8", 64'(s8), 64'(e8[7:0]));
          check("cout8", 64'(co8), 64'(e8[32]));
          check("ovf8", 64'(of8), 64'(e8[33]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      held13 = 1'b0;
    end else begin
      check("in_ready13", 64'(ir13), 64'(!ov13 || or13));
      if (held13) check("hold_data13", 64'({ov13, of13, co13, s13}), 64'({1'b1, hv13[33:32], hv13[12:0]}));
      held13 = ov13 && !or13;
      hv13   = {of13, co13, 19'd0, s13};
      if (iv13 && ir13) q13.push_back(model(13, 32'(a13), 32'(b13), cin13, sub13));
      if (ov13 && or13) begin
        if (q13.size() == 0) check("spurious13", 64'(ov13), 64'd0);
        else begin
          e13 = q13.pop_front();
          check("sum13", 64'(s13), 64'(e13[12:0]));
          check("cout13", 64'(co13), 64'(e13[32]));
          check("ovf13", 64'(of13), 64'(e13[33]));
        end
      end
    end
  end

  // Present one op to the 32-bit DUT until accepted; called just after a rising edge
  task automatic send32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input logic ts, input logic [33:0] e);
    logic done;
    done  = 1'b0;
    a32   = ta;
    b32   = tb;
    cin32 = tc;
    sub32 = ts;
    iv32  = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (ir32) begin
        q32.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    iv32 = 1'b0;
    if (!done) check("send32_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain32(input string tag);
    for (int n = 0; n < 64 && q32.size() != 0; n++) @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, 64'(q32.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned acc, base;
    logic        got;
    logic [31:0] ra, rb;
    logic        rc, rs;

    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    iv8  = 1'b0; or8  = 1'b1; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0;
    iv13 = 1'b0; or13 = 1'b1; a13 = '0; b13 = '0; cin13 = 1'b0; sub13 = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid32", 64'(ov32), 64'd0);
    check("rst_sum32", 64'(s32), 64'd0);
    check("rst_cout32", 64'(co32), 64'd0);
    check("rst_ovf32", 64'(of32), 64'd0);
    check("rst_in_ready32", 64'(ir32), 64'd1);
    check("rst_valid8", 64'(ov8), 64'd0);
    check("rst_valid13", 64'(ov13), 64'd0);
    @(posedge clk);
    #1;

    // Latency on an idle pipeline: 5 + 3
    a32 = 32'd5; b32 = 32'd3; cin32 = 1'b0; sub32 = 1'b0; iv32 = 1'b1;
    @(negedge clk);
    check("lat_accept32", 64'(ir32), 64'd1);
    acc = cyc;
    q32.push_back({1'b0, 1'b0, 32'h0000_0008});
    @(posedge clk);
    #1 iv32 = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ov32) got = 1'b1;
    end
    check("latency32", 64'(cyc - acc), 64'd7);
    @(posedge clk);
    #1;

    // Full carry chain, signed overflow, subtract with borrow and with overflow
    send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    send32(32'd3, 32'd5, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    send32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    drain32("drain_dir32");

    // Back-pressure: 10 back-to-back ops, stall 4 cycles from the 3rd output
    base = n32;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
          send32(ra, rb, rc, rs, model(32, ra, rb, rc, rs));
        end
      end
      begin
        int unsigned seen;
        seen = 0;
        for (int n = 0; n < 200 && seen < 2; n++) begin
          @(negedge clk);
          if (ov32 && or32) seen++;
        end
        check("bp_seen32", 64'(seen), 64'd2);
        @(posedge clk);
        #1 or32 = 1'b0;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          check("bp_valid32", 64'(ov32), 64'd1);
          check("bp_in_ready32", 64'(ir32), 64'd0);
          @(posedge clk);
          #1;
        end
        or32 = 1'b1;
      end
    join
    drain32("drain_bp32");
    check("bp_count32", 64'(n32 - base), 64'd10);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      send32(ra, rb, 1'b0, 1'b0, model(32, ra, rb, 1'b0, 1'b0));
    end
    rst = 1'b1;
    q32.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid32", 64'(ov32), 64'd0);
    check("rst_mid_sum32", 64'(s32), 64'd0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("post_rst_valid32", 64'(ov32), 64'd0);
    end
    @(posedge clk);
    #1;
    send32(32'd1, 32'd1, 1'b0, 1'b0, {1'b0, 1'b0, 32'd2});
    drain32("drain_rst32");

    // Random sweeps on the narrow instances with random valid/ready
    fork
      begin : sweep8
        int unsigned acc8, sent8;
        logic        seen8;
        a8 = 8'd5; b8 = 8'd3; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1; iv8 = 1'b1;
        @(negedge clk);
        check("lat_accept8", 64'(ir8), 64'd1);
        acc8 = cyc;
        @(posedge clk);
        #1 iv8 = 1'b0;
        seen8 = 1'b0;
        for (int n = 0; n < 20 && !seen8; n++) begin
          @(negedge clk);
          if (ov8) seen8 = 1'b1;
        end
        check("latency8", 64'(cyc - acc8), 64'd5);
        @(posedge clk);
        #1;
        sent8 = 0;
        for (int n = 0; n < 20000 && sent8 < 1000; n++) begin
          iv8  = ($urandom_range(0, 3) != 0);
          a8   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
          b8   = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
          cin8 = 1'($urandom);
          sub8 = 1'($urandom);
          or8  = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (iv8 && ir8) sent8++;
          @(posedge clk);
          #1;
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        check("sent8", 64'(sent8), 64'd1000);
      end
      begin : sweep13
        int unsigned acc13, sent13;
        logic        seen13;
        a13 = 13'd5; b13 = 13'd3; cin13 = 1'b0; sub13 = 1'b0; or13 = 1'b1; iv13 = 1'b1;
        @(negedge clk);
        check("lat_accept13", 64'(ir13), 64'd1);
        acc13 = cyc;
        @(posedge clk);
        #1 iv13 = 1'b0;
        seen13 = 1'b0;
        for (int n = 0; n < 20 && !seen13; n++) begin
          @(negedge clk);
          if (ov13) seen13 = 1'b1;
        end
        check("latency13", 64'(cyc - acc13), 64'd6);
        @(posedge clk);
        #1;
        sent13 = 0;
        for (int n = 0; n < 20000 && sent13 < 1000; n++) begin
          iv13  = ($urandom_range(0, 3) != 0);
          a13   = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom);
          b13   = ($urandom_range(0, 7) == 0) ? 13'h1000 : 13'($urandom);
          cin13 = 1'($urandom);
          sub13 = 1'($urandom);
          or13  = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (iv13 && ir13) sent13++;
          @(posedge clk);
          #1;
        end
        iv13 = 1'b0;
        or13 = 1'b1;
        check("sent13", 64'(sent13), 64'd1000);
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("drain8", 64'(q8.size()), 64'd0);
    check("drain13", 64'(q13.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor.
- Generalises the single fixed 32-bit prefix level to a full prefix tree:
  - any WIDTH;
  - a register after every prefix level;
  - carry-in, subtract mode and overflow flags;
  - valid/ready flow control.
- Sits in the datapath as the throughput-oriented adder: one operation accepted per cycle, fixed latency.

Parameters:
- WIDTH, 32: operand width in bits; must be at least 2.
- LEVELS, $clog2(WIDTH): number of prefix levels; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  pipeline can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB; for sub=1, cout=1 means no borrow
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance; it is combinational and never depends on in_valid.
  - Accept occurs when in_valid && in_ready.
  - The whole pipeline moves only when advance=1; when advance=0 every stage holds, including its valid bit.
- Pipeline has LEVELS+2 register stages, each carrying a valid bit.
  - Stage 0 (on accept):
    - bb = sub ? ~b : b; c0 = sub ? 1 : cin.
    - p[i] = a[i]^bb[i]; g[i] = a[i]&bb[i].
    - Bit 0 generate folds in carry-in: g[0] = a[0]&bb[0] | (a[0]^bb[0])&c0.
    - Registers p, g, the raw p (for the sum) and c0.
  - Stage k (1..LEVELS): span d = 2^(k-1).
    - For i >= d, black cell: G[i] = G[i] | P[i]&G[i-d]; P[i] = P[i]&P[i-d].
    - Where i-d reaches a column that is already final (i < 2d), a grey cell: G only; P is no longer needed.
    - For i < d, buffer: G[i] passes through.
    - Raw p and c0 are delayed alongside.
  - Final stage:
    - c[0] = c0; c[i] = G[i-1] for i >= 1.
    - sum[i] = rawp[i] ^ c[i].
    - cout = G[WIDTH-1].
    - ovf = c[WIDTH-1] ^ G[WIDTH-1].
    - Registers sum, cout and ovf, and sets out_valid.
- Latency: exactly LEVELS+2 cycles from accept to out_valid, with no stalls. WIDTH=32 gives 7 cycles.
- Each stall cycle adds one cycle of latency.
- Throughput: one result per cycle while out_ready=1.
- Bubbles (in_valid=0 while advancing) propagate as invalid stages; no result is produced for them.
- Outputs are registered. sum, cout and ovf hold their values while out_valid=1 and out_ready=0.
- Reset:
  - All valid bits clear; sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 in the cycle after reset is released.
  - Datapath registers other than the outputs need no reset.
- Reset mid-operation: in-flight operations are discarded; nothing emerges after reset.
- Simultaneous accept and output handshake in one cycle: legal, and is the normal full-throughput case.
- Non-power-of-2 WIDTH: stages where i-d < 0 for all bits act as buffers; latency is still LEVELS+2.
- Wrap-around:
  - a + b >= 2^WIDTH yields sum modulo 2^WIDTH with cout=1.
  - With sub=1 and a < b (unsigned), sum = a-b+2^WIDTH and cout=0.

Test Plan:
- Latency, WIDTH=32: a=0x0000_0005, b=0x0000_0003, cin=0, sub=0, out_ready=1 -> out_valid exactly 7 cycles after accept; sum=0x8, cout=0, ovf=0.
- Full carry chain: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1, cin=0 -> sum=0x8000_0000, cout=0, ovf=1.
- Subtract:
  - a=3, b=5, sub=1, cin=1 (cin ignored) -> sum=0xFFFF_FFFE, cout=0, ovf=0.
  - a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
- Back-pressure:
  - Stream 10 random ops back-to-back; hold out_ready=0 for 4 cycles starting on the 3rd output -> in_ready=0 during the stall, outputs held stable.
  - All 10 results arrive in order, none lost or duplicated, each matching a reference model.
- Reset mid-stream: 3 ops in flight, assert rst for 1 cycle -> out_valid=0, sum=0 the next cycle; no stale results appear in the following 10 cycles.
- Parameter sweep: WIDTH=8 (latency 5) and WIDTH=13 (latency 6) -> 1000 random add/sub ops each, with random in_valid/out_ready, match the model for sum, cout and ovf.
